// File: rtl/pipe_hazard_ctrl.sv
// Control decode, D/E/M/W control pipeline, NZCV condition evaluation, forwarding and
// stall/flush generation for the 5-stage datapath. Define HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int NREG_BITS   = 4,
  parameter int ALUCTL_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic [NREG_BITS-1:0]   Rd,
  input  logic [3:0]             CondD,
  input  logic [3:0]             AluFlags,
  input  logic [NREG_BITS-1:0]   ra1d,
  input  logic [NREG_BITS-1:0]   ra2d,
  input  logic [NREG_BITS-1:0]   RA1E,
  input  logic [NREG_BITS-1:0]   RA2E,
  input  logic [NREG_BITS-1:0]   WA3E,
  input  logic [NREG_BITS-1:0]   WA3M,
  input  logic [NREG_BITS-1:0]   WA3W,
  output logic [1:0]             RegSrcD,
  output logic [1:0]             ImmSrcD,
  output logic                   ALUSrcE,
  output logic [ALUCTL_BITS-1:0] AluControlE,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic                   BranchTakenE,
  output logic                   MemWriteM,
  output logic                   RegWriteW,
  output logic                   MemtoRegW,
  output logic                   PCSrcW,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  localparam logic [ALUCTL_BITS-1:0] ALU_ADD = ALUCTL_BITS'(0);
  localparam logic [ALUCTL_BITS-1:0] ALU_SUB = ALUCTL_BITS'(1);
  localparam logic [ALUCTL_BITS-1:0] ALU_AND = ALUCTL_BITS'(2);
  localparam logic [ALUCTL_BITS-1:0] ALU_ORR = ALUCTL_BITS'(3);
  localparam logic [NREG_BITS-1:0]   PC_REG  = '1;

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = c;
      4'b0011: cond_check = ~c;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = c & ~z;
      4'b1001: cond_check = ~c | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  logic                   w_reg_write_d, w_mem_write_d, w_memtoreg_d, w_alu_src_d;
  logic                   w_flag_write_d, w_branch_d, w_pcsrc_d;
  logic [ALUCTL_BITS-1:0] w_alu_ctl_d;

  logic                   r_reg_write_e, r_mem_write_e, r_memtoreg_e, r_flag_write_e;
  logic                   r_branch_e, r_pcsrc_e;
  logic [3:0]             r_cond_e;
  logic [3:0]             r_flags;
  logic                   r_reg_write_m, r_memtoreg_m, r_pcsrc_m;

  logic                   w_cond_ex_e, w_ldr_stall, w_pc_wr_pend;

  // Decode stage: held at NOP while reset is asserted so every output reads low
  always_comb begin
    w_reg_write_d  = 1'b0;
    w_mem_write_d  = 1'b0;
    w_memtoreg_d   = 1'b1;
    w_alu_src_d    = 1'b0;
    w_flag_write_d = 1'b0;
    w_branch_d     = 1'b0;
    w_alu_ctl_d    = ALU_ADD;
    RegSrcD        = 2'b00;
    ImmSrcD        = 2'b00;
    if (reset) begin
      case (Opcode)
        2'b00: begin
          w_alu_src_d    = Funct[5];
          w_flag_write_d = Funct[0];
          w_reg_write_d  = 1'b1;
          case (Funct[4:1])
            4'b0100: w_alu_ctl_d = ALU_ADD;
            4'b0010: w_alu_ctl_d = ALU_SUB;
            4'b1010: begin
              w_alu_ctl_d   = ALU_SUB;
              w_reg_write_d = 1'b0;
            end
            4'b0000: w_alu_ctl_d = ALU_AND;
            4'b1100: w_alu_ctl_d = ALU_ORR;
            default: w_reg_write_d = 1'b0;
          endcase
        end
        2'b01: begin
          w_alu_src_d = 1'b1;
          ImmSrcD     = 2'b01;
          w_alu_ctl_d = Funct[3] ? ALU_ADD : ALU_SUB;
          if (Funct[0]) begin
            w_reg_write_d = 1'b1;
            w_memtoreg_d  = 1'b0;
          end else begin
            w_mem_write_d = 1'b1;
            RegSrcD[1]    = 1'b1;
          end
        end
        2'b10: begin
          w_branch_d  = 1'b1;
          w_alu_src_d = 1'b1;
          ImmSrcD     = 2'b10;
          RegSrcD[0]  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_pcsrc_d = (Rd == PC_REG) & w_reg_write_d;

  // Execute stage
  assign w_cond_ex_e  = cond_check(r_cond_e, r_flags);
  assign BranchTakenE = r_branch_e & w_cond_ex_e;

  assign ForwardAE = (r_reg_write_m && RA1E == WA3M) ? 2'b10 :
                     (RegWriteW     && RA1E == WA3W) ? 2'b01 : 2'b00;
  assign ForwardBE = (r_reg_write_m && RA2E == WA3M) ? 2'b10 :
                     (RegWriteW     && RA2E == WA3W) ? 2'b01 : 2'b00;

  assign w_ldr_stall  = ((ra1d == WA3E) | (ra2d == WA3E)) & ~r_memtoreg_e & r_reg_write_e;
  assign w_pc_wr_pend = w_pcsrc_d | r_pcsrc_e | r_pcsrc_m;
  assign StallF       = w_ldr_stall | w_pc_wr_pend;
  assign StallD       = w_ldr_stall;
  assign FlushD       = w_pc_wr_pend | PCSrcW | BranchTakenE;
  assign FlushE       = w_ldr_stall | BranchTakenE;

  // D -> E boundary: a flush turns the slot into a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_e  <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_flag_write_e <= 1'b0;
      r_branch_e     <= 1'b0;
      r_pcsrc_e      <= 1'b0;
      r_cond_e       <= 4'b0000;
      ALUSrcE        <= 1'b0;
      AluControlE    <= ALU_ADD;
    end else if (FlushE) begin
      r_reg_write_e  <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_flag_write_e <= 1'b0;
      r_branch_e     <= 1'b0;
      r_pcsrc_e      <= 1'b0;
      r_cond_e       <= 4'b0000;
      ALUSrcE        <= 1'b0;
      AluControlE    <= ALU_ADD;
    end else begin
      r_reg_write_e  <= w_reg_write_d;
      r_mem_write_e  <= w_mem_write_d;
      r_memtoreg_e   <= w_memtoreg_d;
      r_flag_write_e <= w_flag_write_d;
      r_branch_e     <= w_branch_d;
      r_pcsrc_e      <= w_pcsrc_d;
      r_cond_e       <= CondD;
      ALUSrcE        <= w_alu_src_d;
      AluControlE    <= w_alu_ctl_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (r_flag_write_e && w_cond_ex_e) begin
      r_flags <= AluFlags;
    end
  end

  // E -> M and M -> W boundaries: side effects squashed when the condition fails
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_m <= 1'b0;
      MemWriteM     <= 1'b0;
      r_memtoreg_m  <= 1'b0;
      r_pcsrc_m     <= 1'b0;
      RegWriteW     <= 1'b0;
      MemtoRegW     <= 1'b0;
      PCSrcW        <= 1'b0;
    end else begin
      r_reg_write_m <= r_reg_write_e & w_cond_ex_e;
      MemWriteM     <= r_mem_write_e & w_cond_ex_e;
      r_memtoreg_m  <= r_memtoreg_e;
      r_pcsrc_m     <= r_pcsrc_e & w_cond_ex_e;
      RegWriteW     <= r_reg_write_m;
      MemtoRegW     <= r_memtoreg_m;
      PCSrcW        <= r_pcsrc_m;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (w_ldr_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (BranchTakenE && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed instruction sequences push expected
// output snapshots; a monitor compares them mid-cycle (or on demand during async reset).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] Opcode;
  logic [5:0] Funct;
  logic [3:0] Rd, CondD, AluFlags, ra1d, ra2d, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic [1:0] RegSrcD, ImmSrcD, AluControlE, ForwardAE, ForwardBE;
  logic       ALUSrcE, BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
  logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Rd(Rd), .CondD(CondD),
    .AluFlags(AluFlags), .ra1d(ra1d), .ra2d(ra2d), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .ALUSrcE(ALUSrcE), .AluControlE(AluControlE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  localparam logic [5:0] F_ADD = 6'b001000;
  localparam logic [5:0] F_SUB = 6'b000100;
  localparam logic [5:0] F_CMP = 6'b010101;
  localparam logic [5:0] F_EOR = 6'b000010;
  localparam logic [5:0] F_LDR = 6'b011001;
  localparam logic [5:0] F_STR = 6'b011000;
  localparam logic [5:0] F_B   = 6'b100000;

  localparam logic [19:0] M_ALL    = 20'hFFFFF;
  localparam logic [19:0] M_RS     = 20'hC0000;
  localparam logic [19:0] M_IS     = 20'h30000;
  localparam logic [19:0] M_ALUSRC = 20'h08000;
  localparam logic [19:0] M_ALUC   = 20'h06000;
  localparam logic [19:0] M_FA     = 20'h01800;
  localparam logic [19:0] M_FB     = 20'h00600;
  localparam logic [19:0] M_BT     = 20'h00100;
  localparam logic [19:0] M_MW     = 20'h00080;
  localparam logic [19:0] M_RW     = 20'h00040;
  localparam logic [19:0] M_M2R    = 20'h00020;
  localparam logic [19:0] M_PCW    = 20'h00010;
  localparam logic [19:0] M_HZ     = 20'h0000F;

  typedef struct {
    string       name;
    logic [19:0] exp;
    logic [19:0] mask;
    bit          cnt_chk;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event mon_ev;

  wire [19:0] w_obs = {RegSrcD, ImmSrcD, ALUSrcE, AluControlE, ForwardAE, ForwardBE,
                       BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW,
                       StallF, StallD, FlushD, FlushE};

  // hz = {StallF, StallD, FlushD, FlushE}
  function automatic logic [19:0] mk(input logic [1:0] rs, input logic [1:0] is,
                                     input logic as, input logic [1:0] ac,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic bt, input logic mw, input logic rw,
                                     input logic m2r, input logic pcw, input logic [3:0] hz);
    return {rs, is, as, ac, fa, fb, bt, mw, rw, m2r, pcw, hz};
  endfunction

  task automatic pushc(input string n, input logic [19:0] e, input logic [19:0] m,
                       input bit c, input logic [31:0] s, input logic [31:0] f);
    exp_t x;
    x.name = n; x.exp = e; x.mask = m; x.cnt_chk = c; x.exp_stall = s; x.exp_flush = f;
    sb_q.push_back(x);
  endtask

  task automatic push(input string n, input logic [19:0] e, input logic [19:0] m);
    pushc(n, e, m, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drv_d(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic [3:0] cond, input logic [3:0] r1, input logic [3:0] r2);
    Opcode = op; Funct = fn; Rd = rd; CondD = cond; ra1d = r1; ra2d = r2;
  endtask

  task automatic nop_d();
    drv_d(2'b11, 6'd0, 4'd0, 4'hE, 4'd0, 4'd0);
  endtask

  task automatic drv_e(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] we,
                       input logic [3:0] wm, input logic [3:0] ww);
    RA1E = a1; RA2E = a2; WA3E = we; WA3M = wm; WA3W = ww;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      step();
      nop_d();
      drv_e(0, 0, 0, 0, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: actual=%b required=%b (mask %b)", e.name,
                   w_obs & e.mask, e.exp & e.mask, e.mask);
        end
`ifdef HAZARD_PERF_EN
        if (e.cnt_chk) begin
          n_checks++;
          if (stall_cnt !== e.exp_stall || flush_cnt !== e.exp_flush) begin
            n_fail++;
            $display("FAIL %s_cnt: actual stall=%0d flush=%0d required stall=%0d flush=%0d",
                     e.name, stall_cnt, flush_cnt, e.exp_stall, e.exp_flush);
          end
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1; AluFlags = 4'b0000;
    drv_d(2'b01, F_STR, 4'd15, 4'hE, 4'd1, 4'd2);
    drv_e(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    step();
    push("reset_all", 20'd0, M_ALL);
    step();
    nop_d();
    reset = 1'b1;

    // forwarding: ADD R1 then SUB R2,R1
    step(); drv_d(2'b00, F_ADD, 4'd1, 4'hE, 4'd2, 4'd3); drv_e(0, 0, 0, 0, 0);
    push("add_dec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), M_RS | M_IS | M_HZ);
    step(); drv_d(2'b00, F_SUB, 4'd2, 4'hE, 4'd1, 4'd5); drv_e(2, 3, 1, 0, 0);
    push("add_ex", mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000), M_ALUSRC | M_ALUC | M_FA | M_HZ);
    step(); nop_d(); drv_e(1, 5, 2, 1, 0);
    push("fwdA_M", mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 4'b0000), M_ALUC | M_FA | M_FB | M_HZ);
    step(); nop_d(); drv_e(1, 2, 0, 2, 1);
    push("fwdA_W", mk(0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 1, 0, 0), M_FA | M_FB | M_RW | M_M2R);
    step(); nop_d(); drv_e(2, 0, 0, 2, 2);
    push("fwdA_Wonly", mk(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), M_FA | M_FB);
    drain();

    // M beats W when both match; unknown cmd writes nothing even to R15
    step(); drv_d(2'b00, F_ADD, 4'd9, 4'hE, 4'd0, 4'd0);
    step();
    step(); nop_d();
    step(); drv_e(9, 9, 0, 9, 9);
    push("fwd_prio", mk(0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0), M_FA | M_FB);
    step(); drv_d(2'b00, F_EOR, 4'd15, 4'hE, 4'd0, 4'd0); drv_e(0, 0, 0, 0, 0);
    push("eor_nowrite", 20'd0, M_HZ);
    step(); nop_d();
    push("eor_ex", 20'd0, M_HZ);
    drain();

    // load-use stall
    step(); drv_d(2'b01, F_LDR, 4'd3, 4'hE, 4'd4, 4'd0); drv_e(0, 0, 0, 0, 0);
    push("ldr_dec", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), M_RS | M_IS | M_HZ);
    step(); drv_d(2'b00, F_ADD, 4'd4, 4'hE, 4'd3, 4'd6); drv_e(4, 0, 3, 0, 0);
    push("ldr_stall", mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b1101), M_ALUSRC | M_ALUC | M_HZ);
    step(); drv_e(0, 0, 3, 3, 0);
    push("ldr_bubble", 20'd0, M_HZ);
    step(); nop_d(); drv_e(3, 6, 4, 0, 3);
    push("ldr_fwdW", mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 4'b0000), M_FA | M_RW | M_M2R | M_HZ);
    drain();

    // CMP sets Z, BEQ taken, BNE not taken
    step(); drv_d(2'b00, F_CMP, 4'd0, 4'hE, 4'd1, 4'd2); AluFlags = 4'b0100;
    push("cmp_dec", 20'd0, M_RS | M_IS | M_HZ);
    step(); drv_d(2'b10, F_B, 4'd0, 4'b0000, 4'd0, 4'd0); drv_e(1, 2, 0, 0, 0);
    push("beq_dec", mk(2'b01, 2'b10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0000), M_RS | M_IS | M_ALUC | M_HZ);
    step(); nop_d(); drv_e(0, 0, 0, 0, 0); AluFlags = 4'b0000;
    push("beq_taken", mk(0, 0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 4'b0011), M_ALUSRC | M_ALUC | M_BT | M_HZ);
    step(); drv_d(2'b10, F_B, 4'd0, 4'b0001, 4'd0, 4'd0);
    push("beq_bubble", 20'd0, M_BT | M_HZ);
    step(); nop_d();
    push("bne_not", 20'd0, M_BT | M_HZ);
    drain();

    // write to R15
    step(); drv_d(2'b00, F_ADD, 4'd15, 4'hE, 4'd0, 4'd0);
    push("pc_d", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010), M_HZ);
    step(); nop_d();
    push("pc_e", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010), M_HZ);
    step();
    push("pc_m", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010), M_HZ);
    step();
    push("pc_w", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0010), M_PCW | M_RW | M_HZ);
    step();
    push("pc_done", 20'd0, M_PCW | M_HZ);
    drain();

    // conditional STR: EQ with Z=0 then Z=1
    step(); drv_d(2'b00, F_CMP, 4'd0, 4'hE, 4'd1, 4'd2); AluFlags = 4'b0000;
    step(); drv_d(2'b01, F_STR, 4'd7, 4'b0000, 4'd8, 4'd7);
    push("str_dec", mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_RS | M_IS);
    step(); nop_d();
    step(); drv_d(2'b00, F_CMP, 4'd0, 4'hE, 4'd1, 4'd2); AluFlags = 4'b0100;
    push("str_z0", 20'd0, M_MW);
    step(); drv_d(2'b01, F_STR, 4'd7, 4'b0000, 4'd8, 4'd7);
    push("str_dec2", mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_RS);
    step(); nop_d(); AluFlags = 4'b0000;
    step();
    push("str_z1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), M_MW);
    step();
    push("str_done", 20'd0, M_MW);
    drain();

    // asynchronous reset in the middle of a load-use stall
    step(); drv_d(2'b01, F_LDR, 4'd3, 4'hE, 4'd4, 4'd0); drv_e(0, 0, 0, 0, 0);
    step(); drv_d(2'b00, F_ADD, 4'd4, 4'hE, 4'd3, 4'd6); drv_e(4, 0, 3, 0, 0);
    pushc("stall_again", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101), M_HZ, 1'b1, 32'd1, 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    pushc("reset_mid", 20'd0, M_ALL, 1'b1, 32'd0, 32'd0);
    -> mon_ev;
    #1;
    step(); nop_d(); drv_e(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    push("post_reset", 20'd0, M_ALL);
    step();
    step();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
